// File: rtl/icache_types.sv
// Shared constants and types for the direct-mapped instruction cache.
// The line is 32 bytes (256 bits). The cache has 2**S_INDEX sets.
package icache_types;

  localparam int unsigned S_OFFSET = 5;
  localparam int unsigned S_INDEX  = 3;
  localparam int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int unsigned SETS     = 1 << S_INDEX;

  typedef enum logic {LOOKUP, FILL} icache_state_t;

  typedef logic [255:0] line_t;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side (inst_*) and fill-side (pmem_*) signals of the instruction cache.
// The slave modport is the cache's view. The master modport drives the cache from outside.
interface inst_cache_if;
  import icache_types::*;

  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic        pmem_read;
  logic [31:0] pmem_address;
  line_t       pmem_rdata;
  logic        pmem_resp;

  modport master (
    output inst_read, inst_addr, pmem_rdata, pmem_resp,
    input  inst_resp, inst_rdata, pmem_read, pmem_address
  );

  modport slave (
    input  inst_read, inst_addr, pmem_rdata, pmem_resp,
    output inst_resp, inst_rdata, pmem_read, pmem_address
  );

endinterface

// File: rtl/icache_array.sv
// Tag, valid and data storage. It has one write port and a combinational read port.
// Only the valid bits are reset, so a set must be refilled before it can hit.
module icache_array
  import icache_types::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [S_INDEX-1:0] widx,
  input  logic [S_TAG-1:0]   wtag,
  input  line_t              wline,
  input  logic [S_INDEX-1:0] ridx,
  output logic               rvalid,
  output logic [S_TAG-1:0]   rtag,
  output line_t              rline
);

  logic [SETS-1:0]  valid_q;
  logic [S_TAG-1:0] tag_q  [SETS];
  line_t            data_q [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wline;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rline  = data_q[ridx];

endmodule

// File: rtl/inst_cache.sv
// Read-only, direct-mapped instruction cache. A hit answers in the same cycle.
// A miss stalls fetch while one 256-bit line is filled over the pmem port.
module inst_cache
  import icache_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  inst_cache_if.slave  bus
);

  icache_state_t state_q, state_d;
  logic [31:0]   miss_addr_q, miss_addr_d;

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] req_idx;
  logic [2:0]         req_word;
  logic               arr_valid;
  logic [S_TAG-1:0]   arr_tag;
  line_t              arr_line;
  logic               hit;
  logic               fill_we;
  logic               unused_addr_bits;

  assign req_tag          = bus.inst_addr[31 -: S_TAG];
  assign req_idx          = bus.inst_addr[S_OFFSET +: S_INDEX];
  assign req_word         = bus.inst_addr[4:2];
  assign unused_addr_bits = ^bus.inst_addr[1:0];

  icache_array u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (fill_we),
    .widx   (miss_addr_q[S_OFFSET +: S_INDEX]),
    .wtag   (miss_addr_q[31 -: S_TAG]),
    .wline  (bus.pmem_rdata),
    .ridx   (req_idx),
    .rvalid (arr_valid),
    .rtag   (arr_tag),
    .rline  (arr_line)
  );

  assign hit = arr_valid && (arr_tag == req_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOOKUP;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    miss_addr_d      = miss_addr_q;
    fill_we          = 1'b0;
    bus.inst_resp    = 1'b0;
    bus.inst_rdata   = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_address = '0;
    unique case (state_q)
      LOOKUP: begin
        // pmem_resp is deliberately not looked at here: a stray response must not write the array.
        if (bus.inst_read) begin
          if (hit) begin
            bus.inst_resp  = 1'b1;
            bus.inst_rdata = arr_line[{req_word, 5'b0} +: 32];
          end else begin
            miss_addr_d = {bus.inst_addr[31:5], 5'b0};
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = miss_addr_q;
        if (bus.pmem_resp) begin
          fill_we = 1'b1;
          state_d = LOOKUP;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_inst_cache.sv
// Randomized scoreboard bench for inst_cache. The reference model records which line lives in
// each set, and every word is regenerated from a fixed memory function.
module tb_inst_cache;
  import icache_types::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
  } exp_t;

  logic clk;
  logic rst_n;
  inst_cache_if bus ();

  inst_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  bit          directed = 1'b1;
  bit          resp_en = 1'b0;
  bit          glitch = 1'b0;
  bit          abort = 1'b0;
  int          fixed_lat = -1;
  logic [31:0] res_line [SETS];
  bit          res_valid [SETS];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_006C) return 32'h00A0_0093;
    return {w[15:0] ^ 16'hA5C3, ~w[15:0]};
  endfunction

  function automatic line_t line_of(input logic [31:0] base);
    line_t l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(base + 32'(4 * k));
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.inst_read = 1'b0;
    bus.inst_addr = $urandom;
  endtask

  // Issue one fetch and hold it until the cache answers. With distract set, a different address
  // is shown while the fill is in flight.
  task automatic fetch(input logic [31:0] a, input bit distract);
    exp_t        e;
    logic [31:0] line;
    int unsigned idx;
    bit          got;
    if (abort) return;
    line   = a & ~32'h1F;
    idx    = int'(a[7:5]);
    e.addr = a;
    e.data = mem_word(a);
    e.miss = !(res_valid[idx] && res_line[idx] == line);
    q.push_back(e);
    res_valid[idx] = 1'b1;
    res_line[idx]  = line;
    @(posedge clk); #1;
    bus.inst_read = 1'b1;
    bus.inst_addr = a;
    if (glitch) begin
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = ~line_of(line);
    end
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (bus.inst_resp) begin
        got = 1'b1;
      end else begin
        logic [31:0] nxt;
        nxt = (distract && bus.pmem_read && !bus.pmem_resp) ? (a ^ 32'h100) : a;
        @(posedge clk); #1;
        bus.inst_addr = nxt;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      abort = 1'b1;
      $display("FAIL fetch_timeout: addr %h got no inst_resp within 60 cycles", a);
    end
  endtask

  // Memory side: answer each fill after a fixed or random latency.
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && bus.pmem_read) begin
        int lat;
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        repeat (lat) begin
          @(posedge clk); #1;
        end
        bus.pmem_rdata = line_of(bus.pmem_address);
        bus.pmem_resp  = 1'b1;
        @(posedge clk); #1;
        bus.pmem_resp  = 1'b0;
      end
    end
  end

  // Monitor: pops one expectation for each reported hit and checks the fill in between.
  initial begin
    int   cyc;
    int   resp_cyc;
    bit   fill_seen;
    exp_t e;
    cyc       = 0;
    resp_cyc  = 0;
    fill_seen = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (directed) begin
        fill_seen = 1'b0;
      end else begin
        if (!bus.inst_resp) chk("rdata_zero_when_idle", bus.inst_rdata, 32'h0);
        if (bus.pmem_read) begin
          chk("fill_expected", {31'b0, (q.size() != 0 && q[0].miss)}, 32'h1);
          if (q.size() != 0) chk("pmem_address", bus.pmem_address, q[0].addr & ~32'h1F);
          fill_seen = 1'b1;
          if (bus.pmem_resp) resp_cyc = cyc;
        end
        if (bus.inst_resp) begin
          chk("pmem_read_on_hit", {31'b0, bus.pmem_read}, 32'h0);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: inst_resp=1 rdata %h with nothing outstanding",
                     bus.inst_rdata);
          end else begin
            e = q.pop_front();
            chk("inst_rdata", bus.inst_rdata, e.data);
            chk("miss_fill", {31'b0, fill_seen}, {31'b0, e.miss});
            if (e.miss) chk("miss_latency", 32'(cyc), 32'(resp_cyc + 1));
          end
          fill_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(SETS); i++) res_valid[i] = 1'b0;
    rst_n         = 1'b0;
    bus.inst_read = 1'b0;
    bus.inst_addr = '0;
    @(negedge clk);
    chk("reset_inst_resp", {31'b0, bus.inst_resp}, 32'h0);
    chk("reset_inst_rdata", bus.inst_rdata, 32'h0);
    chk("reset_pmem_read", {31'b0, bus.pmem_read}, 32'h0);
    chk("reset_pmem_address", bus.pmem_address, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    directed = 1'b0;
    resp_en  = 1'b1;

    // Cold miss with a three-cycle memory, then stream the whole line.
    fixed_lat = 3;
    fetch(32'h6C, 1'b0);
    for (int k = 0; k < 8; k++) fetch(32'h60 + 32'(4 * k), 1'b0);
    // Conflict in set 3.
    fetch(32'h160, 1'b0);
    fetch(32'h60, 1'b0);
    // A stray pmem_resp during hits must not disturb the resident line.
    glitch = 1'b1;
    fetch(32'h60, 1'b0);
    fetch(32'h64, 1'b0);
    glitch = 1'b0;
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    bus.inst_read = 1'b0;
    fetch(32'h60, 1'b0);
    fetch(32'h7C, 1'b0);
    // The fill stays on the latched line while fetch wanders.
    fetch(32'h200, 1'b1);
    fetch(32'h300, 1'b0);
    fetch(32'h200, 1'b0);
    idle();

    // Reset in the middle of a fill.
    if (!abort) begin
      directed = 1'b1;
      resp_en  = 1'b0;
      @(posedge clk); #1;
      bus.inst_read = 1'b1;
      bus.inst_addr = 32'h400;
      @(negedge clk);
      chk("rst_fill_miss_resp", {31'b0, bus.inst_resp}, 32'h0);
      @(negedge clk);
      chk("rst_fill_pmem_read", {31'b0, bus.pmem_read}, 32'h1);
      chk("rst_fill_pmem_address", bus.pmem_address, 32'h400);
      rst_n = 1'b0;
      #1;
      chk("rst_async_pmem_read", {31'b0, bus.pmem_read}, 32'h0);
      chk("rst_async_pmem_address", bus.pmem_address, 32'h0);
      @(negedge clk);
      bus.inst_read = 1'b0;
      rst_n         = 1'b1;
      @(posedge clk); #1;
      bus.pmem_rdata = line_of(32'h400);
      bus.pmem_resp  = 1'b1;
      @(posedge clk); #1;
      bus.pmem_resp  = 1'b0;
      @(negedge clk);
      chk("stale_resp_pmem_read", {31'b0, bus.pmem_read}, 32'h0);
      chk("stale_resp_inst_resp", {31'b0, bus.inst_resp}, 32'h0);
      for (int i = 0; i < int'(SETS); i++) res_valid[i] = 1'b0;
      directed = 1'b0;
      resp_en  = 1'b1;
    end
    fetch(32'h60, 1'b0);
    fetch(32'h200, 1'b0);
    fetch(32'h400, 1'b0);

    // Random traffic over four tags so sets conflict often.
    fixed_lat = -1;
    for (int n = 0; n < 200 && !abort; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) idle();
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) |
          (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      fetch(a, $urandom_range(0, 3) == 0);
    end

    idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
